debug_host_link: RTL and testbench
==================================

Name: debug_host_link

Overview:
- Host-side initiator for the debug unit's UART protocol; it is the far end of the debug link.
- Drives a UART transmitter to download a program, select the execution mode and issue step commands.
- Collects the byte stream the debug unit returns (PC, register bank, data memory) and reassembles it into 32-bit words.
- Used as the bench/host model and as an on-board loopback master.

Parameters:
DATA_WIDTH, 32, instruction/response word width (multiple of 8)
DATA_WIDTH_UART, 8, UART byte width
N_REGS, 32, register words returned per dump
N_MEM, 32, memory words returned per dump
TIMEOUT_CYCLES, 2000000, max idle cycles between received bytes before error

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_cmd_valid  in  1  command request, sampled in IDLE only
i_cmd  in  2  0=LOAD, 1=RUN, 2=STEP, 3=reserved (ignored)
i_word  in  DATA_WIDTH  program word for LOAD
i_word_valid  in  1  program word available
o_word_ready  out  1  program word accepted this cycle
i_tx_done  in  1  UART transmitter byte-complete pulse
i_rx_done  in  1  UART receiver byte-valid pulse
i_rx_data  in  DATA_WIDTH_UART  received byte
o_tx_signal  out  1  one-cycle start pulse to UART transmitter
o_tx_result  out  DATA_WIDTH_UART  byte to transmit, stable until i_tx_done
o_resp_valid  out  1  one-cycle pulse, o_resp_word valid
o_resp_word  out  DATA_WIDTH  reassembled response word
o_resp_index  out  7  0=PC, 1..N_REGS=regs, then memory
o_busy  out  1  high whenever state != IDLE
o_done  out  1  one-cycle pulse at normal completion of any command
o_error  out  1  sticky timeout flag, cleared by next accepted command

Behaviour:
- Reset (i_reset=0, async) values: state=IDLE; all outputs 0; byte, word and timeout counters 0.
- Byte order is MSB first on both directions; bytes = DATA_WIDTH/8.
- TX handshake:
  - Load o_tx_result and pulse o_tx_signal in the same cycle.
  - Hold o_tx_result and wait for i_tx_done; never issue a new pulse before it.
  - The next byte's pulse comes no earlier than the cycle after i_tx_done.
- States:
  - IDLE: accept i_cmd_valid. LOAD→LD_HDR; RUN→CMD with byte 0x0F; STEP→CMD with byte 0xAA; reserved→stay IDLE.
  - LD_HDR: send 0xFF (load header) → LD_FETCH.
  - LD_FETCH: when i_word_valid, assert o_word_ready for one cycle, latch word, → LD_BYTE.
  - LD_BYTE: send the latched word byte by byte. After the last byte: if the word was 0x00000000 (halt/terminator) → MODE; else → LD_FETCH.
  - MODE: send 0xFF (debug mode select) → o_done pulse → IDLE.
  - CMD: send the command byte. RUN → RX_COLLECT once (program completes, unit dumps). STEP → RX_COLLECT.
  - RX_COLLECT: shift each i_rx_done byte into an accumulator.
    - On every DATA_WIDTH/8-th byte: pulse o_resp_valid with the word and o_resp_index, then increment the index.
    - After 1+N_REGS+N_MEM words: o_done pulse → IDLE.
  - ERR: entered from RX_COLLECT when the timeout counter reaches TIMEOUT_CYCLES. Sets o_error, → IDLE; partial word discarded.
- Timeout counter: cleared on each i_rx_done and on entry to RX_COLLECT; counts only in RX_COLLECT.
- i_rx_done outside RX_COLLECT: byte ignored (no response, no error).
- i_rx_done in the same cycle as a timeout: the byte wins and the counter clears.
- i_cmd_valid while busy: ignored, not queued.
- o_resp_word holds its last value between pulses.
- Reset mid-transfer: immediate abort, outputs cleared. The UART may finish the current byte; the resulting i_tx_done is ignored in IDLE.
- Latency: first o_tx_signal is 1 cycle after the command is accepted. o_resp_valid is 1 cycle after the last byte's i_rx_done.

Decomposition:
- Package debug_link_pkg:
  - Command encodings.
  - Protocol byte constants: LOAD_HDR=0xFF, MODE_DEBUG=0xFF, MODE_RUN=0x0F, CMD_STEP=0xAA.
  - State encoding.
  - Helper constant BYTES_PER_WORD.
- One sub-module: debug_word_assembler (byte shifter + byte count + word-valid pulse), reused for response reassembly.

Test Plan:
- Reset: hold i_reset=0 mid-LOAD → all outputs 0, state IDLE; release → o_busy=0.
- LOAD of words 0x20010002, 0x00000000 against the UART+DEBUG_UNIT pair:
  - Required tx bytes: FF,20,01,00,02,00,00,00,00,FF.
  - o_word_ready pulses twice; o_done once.
- STEP with responder model returning PC=0x80E17021, regs=index, mem=~index:
  - 65 o_resp_valid pulses.
  - Word 0 = 0x80E17021; word 64 = ~31.
  - Then o_done.
- Timeout: STEP, responder stops after 5 bytes with TIMEOUT_CYCLES=1000 → o_error=1 at cycle 1000 after byte 5, returns to IDLE.
- Back-pressure and ignored inputs:
  - Delay i_tx_done by 12800 cycles per byte → o_tx_result stable and no extra o_tx_signal.
  - i_cmd_valid while busy is ignored.
- Stray i_rx_done in IDLE → no o_resp_valid, no o_error.

Source files
------------

// File: rtl/debug_link_pkg.sv
// Shared encodings for the host side of the debug-unit UART link.
package debug_link_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_RUN  = 2'd1,
    OP_STEP = 2'd2,
    OP_RSVD = 2'd3
  } cmd_e;

  localparam logic [7:0] LOAD_HDR   = 8'hFF;
  localparam logic [7:0] MODE_DEBUG = 8'hFF;
  localparam logic [7:0] MODE_RUN   = 8'h0F;
  localparam logic [7:0] CMD_STEP   = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_HDR,
    ST_LD_FETCH,
    ST_LD_BYTE,
    ST_MODE,
    ST_CMD,
    ST_RX_COLLECT,
    ST_ERR
  } state_e;

  function automatic int bytes_per_word(input int word_w, input int byte_w);
    return word_w / byte_w;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(32, 8);

endpackage

// File: rtl/debug_word_assembler.sv
// MSB-first byte-to-word shifter; pulses word_valid one cycle after the last byte of a word.
module debug_word_assembler
  import debug_link_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  gclk,
  input  logic                  grst_n,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_valid
);

  localparam int BPW = bytes_per_word(DATA_WIDTH, BYTE_WIDTH);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST = CW'(BPW - 1);

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] next_acc;
  logic [CW-1:0]         cnt;

  assign next_acc = (acc << BYTE_WIDTH) | DATA_WIDTH'(byte_data);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      acc        <= '0;
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (byte_valid) begin
        acc <= next_acc;
        if (cnt == LAST) begin
          cnt        <= '0;
          word       <= next_acc;
          word_valid <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/debug_host_link.sv
// Host-side initiator for the debug-unit UART link: program download, mode select,
// step/run commands and reassembly of the PC/register/memory dump.
module debug_host_link
  import debug_link_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8,
  parameter int N_REGS          = 32,
  parameter int N_MEM           = 32,
  parameter int TIMEOUT_CYCLES  = 2000000
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_cmd_valid,
  input  logic [1:0]                 i_cmd,
  input  logic [DATA_WIDTH-1:0]      i_word,
  input  logic                       i_word_valid,
  output logic                       o_word_ready,
  input  logic                       i_tx_done,
  input  logic                       i_rx_done,
  input  logic [DATA_WIDTH_UART-1:0] i_rx_data,
  output logic                       o_tx_signal,
  output logic [DATA_WIDTH_UART-1:0] o_tx_result,
  output logic                       o_resp_valid,
  output logic [DATA_WIDTH-1:0]      o_resp_word,
  output logic [6:0]                 o_resp_index,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error
);

  localparam int BPW = bytes_per_word(DATA_WIDTH, DATA_WIDTH_UART);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]    LAST_IDX  = 7'(N_REGS + N_MEM);

  state_e                state;
  logic [DATA_WIDTH-1:0] ld_shift;
  logic                  ld_halt;
  logic [CW-1:0]         byte_cnt;
  logic [TW-1:0]         to_cnt;
  logic [6:0]            idx;
  logic                  rx_take;
  logic                  asm_clear;
  logic                  asm_valid;
  logic [DATA_WIDTH-1:0] asm_word;

  // Bytes arriving outside a dump are dropped before they reach the shifter.
  assign rx_take   = (state == ST_RX_COLLECT) && i_rx_done;
  assign asm_clear = ((state == ST_CMD) && i_tx_done) || (state == ST_ERR);

  assign o_word_ready = (state == ST_LD_FETCH) && i_word_valid;
  assign o_busy       = (state != ST_IDLE);
  assign o_resp_valid = asm_valid;
  assign o_resp_word  = asm_word;
  assign o_resp_index = idx;

  debug_word_assembler #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (DATA_WIDTH_UART)
  ) u_asm (
    .gclk       (i_clock),
    .grst_n     (i_reset),
    .clear      (asm_clear),
    .byte_valid (rx_take),
    .byte_data  (i_rx_data),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= ST_IDLE;
      o_tx_signal <= 1'b0;
      o_tx_result <= '0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      ld_shift    <= '0;
      ld_halt     <= 1'b0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      idx         <= '0;
    end else begin
      o_tx_signal <= 1'b0;
      o_done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            case (cmd_e'(i_cmd))
              OP_LOAD: begin
                o_error     <= 1'b0;
                o_tx_signal <= 1'b1;
                o_tx_result <= DATA_WIDTH_UART'(LOAD_HDR);
                state       <= ST_LD_HDR;
              end
              OP_RUN: begin
                o_error     <= 1'b0;
                o_tx_signal <= 1'b1;
                o_tx_result <= DATA_WIDTH_UART'(MODE_RUN);
                state       <= ST_CMD;
              end
              OP_STEP: begin
                o_error     <= 1'b0;
                o_tx_signal <= 1'b1;
                o_tx_result <= DATA_WIDTH_UART'(CMD_STEP);
                state       <= ST_CMD;
              end
              default: ;
            endcase
          end
        end
        ST_LD_HDR: begin
          if (i_tx_done) state <= ST_LD_FETCH;
        end
        ST_LD_FETCH: begin
          if (i_word_valid) begin
            o_tx_signal <= 1'b1;
            o_tx_result <= i_word[DATA_WIDTH-1 -: DATA_WIDTH_UART];
            ld_shift    <= i_word << DATA_WIDTH_UART;
            ld_halt     <= (i_word == '0);
            byte_cnt    <= '0;
            state       <= ST_LD_BYTE;
          end
        end
        ST_LD_BYTE: begin
          if (i_tx_done) begin
            if (byte_cnt == LAST_BYTE) begin
              // An all-zero word is the program terminator.
              if (ld_halt) begin
                o_tx_signal <= 1'b1;
                o_tx_result <= DATA_WIDTH_UART'(MODE_DEBUG);
                state       <= ST_MODE;
              end else begin
                state <= ST_LD_FETCH;
              end
            end else begin
              o_tx_signal <= 1'b1;
              o_tx_result <= ld_shift[DATA_WIDTH-1 -: DATA_WIDTH_UART];
              ld_shift    <= ld_shift << DATA_WIDTH_UART;
              byte_cnt    <= byte_cnt + CW'(1);
            end
          end
        end
        ST_MODE: begin
          if (i_tx_done) begin
            o_done <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_CMD: begin
          if (i_tx_done) begin
            to_cnt <= '0;
            idx    <= '0;
            state  <= ST_RX_COLLECT;
          end
        end
        ST_RX_COLLECT: begin
          // A byte landing on the timeout cycle still counts and restarts the window.
          if (i_rx_done)              to_cnt <= '0;
          else if (to_cnt == TO_LAST) state  <= ST_ERR;
          else                        to_cnt <= to_cnt + TW'(1);
          if (asm_valid) begin
            idx <= idx + 7'd1;
            if (idx == LAST_IDX) begin
              o_done <= 1'b1;
              state  <= ST_IDLE;
            end
          end
        end
        ST_ERR: begin
          o_error <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_host_link.sv
// Scoreboarded bench: stimulus queues expected TX bytes and response words, monitors pop them.
module tb_debug_host_link;
  import debug_link_pkg::*;

  localparam int DW = 32;
  localparam int BW = 8;
  localparam int NR = 32;
  localparam int NM = 32;
  localparam int TO = 1000;
  localparam int NW = 1 + NR + NM;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic          i_cmd_valid;
  logic [1:0]    i_cmd;
  logic [DW-1:0] i_word;
  logic          i_word_valid;
  logic          o_word_ready;
  logic          i_tx_done;
  logic          i_rx_done;
  logic [BW-1:0] i_rx_data;
  logic          o_tx_signal;
  logic [BW-1:0] o_tx_result;
  logic          o_resp_valid;
  logic [DW-1:0] o_resp_word;
  logic [6:0]    o_resp_index;
  logic          o_busy;
  logic          o_done;
  logic          o_error;

  always #5 i_clock = ~i_clock;

  debug_host_link #(
    .DATA_WIDTH(DW), .DATA_WIDTH_UART(BW), .N_REGS(NR), .N_MEM(NM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .i_word(i_word), .i_word_valid(i_word_valid), .o_word_ready(o_word_ready),
    .i_tx_done(i_tx_done), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
    .o_tx_signal(o_tx_signal), .o_tx_result(o_tx_result), .o_resp_valid(o_resp_valid),
    .o_resp_word(o_resp_word), .o_resp_index(o_resp_index), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error)
  );

  typedef struct packed {
    logic [31:0] word;
    logic [6:0]  index;
  } resp_t;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  exp_tx[$];
  resp_t       exp_resp[$];
  logic [31:0] prog[$];
  logic [31:0] dump_words[NW];
  int tx_delay = 0;
  int tx_pulses = 0;
  int tx_dones = 0;
  bit tx_busy = 0;
  int done_cnt = 0;
  int ready_cnt = 0;
  int resp_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] got);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h, nothing expected", name, got);
  endtask

  function automatic int cnt_of(input int kind);
    case (kind)
      0:       return tx_dones;
      1:       return done_cnt;
      default: return tx_pulses;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  task automatic wait_for(input int kind, input int target, input int limit, input string name);
    int n = 0;
    while (cnt_of(kind) < target && n < limit) begin
      @(negedge i_clock);
      n++;
    end
    check(name, cnt_of(kind) >= target, 1);
  endtask

  task automatic push_word_bytes(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_tx.push_back(w[8*b +: 8]);
  endtask

  task automatic issue(input logic [1:0] c, input bit expect_tx);
    @(negedge i_clock);
    i_cmd = c;
    i_cmd_valid = 1'b1;
    @(negedge i_clock);
    i_cmd_valid = 1'b0;
    if (expect_tx) check("tx_latency", o_tx_signal, 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input int gap);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clock);
    i_rx_done = 1'b0;
    repeat (gap) @(negedge i_clock);
  endtask

  // UART transmitter model: accepts a pulse, holds for a delay, then reports byte-complete.
  initial begin : tx_uart
    logic [7:0] b;
    bit stable, aborted;
    int d;
    i_tx_done = 1'b0;
    forever begin
      @(negedge i_clock);
      i_tx_done = 1'b0;
      if (o_tx_signal === 1'b1) begin
        b = o_tx_result;
        tx_pulses++;
        tx_busy = 1;
        if (exp_tx.size() == 0) fail_now("tx_unexpected", b);
        else check("tx_byte", b, exp_tx.pop_front());
        d = (tx_delay > 0) ? tx_delay : int'($urandom_range(1, 4));
        stable = 1;
        aborted = 0;
        for (int k = 0; k < d; k++) begin
          @(negedge i_clock);
          if (!i_reset) aborted = 1;
          else if (o_tx_signal !== 1'b0 || o_tx_result !== b) stable = 0;
        end
        if (!aborted) check("tx_hold", stable, 1);
        i_tx_done = 1'b1;
        tx_dones++;
        tx_busy = 0;
      end
    end
  end

  always @(negedge i_clock) begin
    if (o_done === 1'b1) done_cnt++;
    if (o_resp_valid === 1'b1) begin
      resp_t e;
      resp_cnt++;
      if (exp_resp.size() == 0) fail_now("resp_unexpected", o_resp_word);
      else begin
        e = exp_resp.pop_front();
        check("resp_word", o_resp_word, e.word);
        check("resp_index", o_resp_index, e.index);
      end
    end
  end

  always begin
    @(negedge i_clock);
    #1;
    if (o_word_ready === 1'b1) ready_cnt++;
  end

  task automatic run_load();
    int d0, k0, n;
    exp_tx.push_back(8'hFF);
    foreach (prog[i]) push_word_bytes(prog[i]);
    exp_tx.push_back(8'hFF);
    d0 = done_cnt;
    k0 = ready_cnt;
    issue(OP_LOAD, 1);
    check("load_err_clear", o_error, 0);
    foreach (prog[i]) begin
      tick($urandom_range(0, 5));
      i_word = prog[i];
      i_word_valid = 1'b1;
      #1;
      n = 0;
      while (!o_word_ready && n < 400) begin
        @(negedge i_clock);
        #1;
        n++;
      end
      check("word_accepted", o_word_ready, 1);
      @(negedge i_clock);
      i_word_valid = 1'b0;
    end
    wait_for(1, d0 + 1, 400, "load_done_seen");
    tick(3);
    check("load_done_once", done_cnt - d0, 1);
    check("load_ready_pulses", ready_cnt - k0, prog.size());
    check("load_tx_all_sent", exp_tx.size(), 0);
    check("load_idle", o_busy, 0);
  endtask

  task automatic run_dump(input logic [1:0] c, input bit poke_busy);
    int d0, r0, t0;
    exp_tx.push_back((c == OP_STEP) ? 8'hAA : 8'h0F);
    for (int i = 0; i < NW; i++) exp_resp.push_back('{word: dump_words[i], index: 7'(i)});
    d0 = done_cnt;
    r0 = resp_cnt;
    t0 = tx_dones;
    issue(c, 1);
    check("dump_err_clear", o_error, 0);
    if (poke_busy) begin
      tick(100);
      @(negedge i_clock);
      i_cmd = OP_LOAD;
      i_cmd_valid = 1'b1;
      @(negedge i_clock);
      i_cmd_valid = 1'b0;
      check("busy_during_cmd", o_busy, 1);
    end
    wait_for(0, t0 + 1, tx_delay + 50, "cmd_tx_done");
    tick(2);
    for (int i = 0; i < NW; i++)
      for (int b = 3; b >= 0; b--) send_rx(dump_words[i][8*b +: 8], $urandom_range(0, 3));
    wait_for(1, d0 + 1, 50, "dump_done_seen");
    tick(3);
    check("dump_done_once", done_cnt - d0, 1);
    check("dump_resp_count", resp_cnt - r0, NW);
    check("dump_queue_empty", exp_resp.size(), 0);
    check("dump_idle", o_busy, 0);
  endtask

  task automatic random_prog();
    logic [31:0] w;
    prog.delete();
    repeat ($urandom_range(1, 4)) begin
      w = $urandom;
      if (w == 32'h0) w = 32'h1;
      prog.push_back(w);
    end
    prog.push_back(32'h0);
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  initial begin
    #1_000_000;
    fail_now("watchdog_expired", 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d0, r0, t0, n;
    logic [31:0] w;
    i_reset = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd = 2'd0;
    i_word = '0;
    i_word_valid = 1'b0;
    i_rx_done = 1'b0;
    i_rx_data = '0;
    tick(3);
    check("rst_busy", o_busy, 0);
    check("rst_tx_signal", o_tx_signal, 0);
    @(negedge i_clock);
    i_reset = 1'b1;
    tick(2);
    check("post_rst_busy", o_busy, 0);
    check("post_rst_error", o_error, 0);

    // Directed program download ending in the terminator word.
    prog.delete();
    prog.push_back(32'h20010002);
    prog.push_back(32'h00000000);
    run_load();

    // Directed STEP dump: PC, regs = index, mem = ~index.
    dump_words[0] = 32'h80E17021;
    for (int i = 0; i < NR; i++) dump_words[1 + i] = 32'(i);
    for (int i = 0; i < NM; i++) dump_words[1 + NR + i] = ~32'(i);
    run_dump(OP_STEP, 0);

    for (int r = 0; r < 2; r++) begin
      random_prog();
      run_load();
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NW; i++) dump_words[i] = $urandom;
      run_dump((r == 0) ? OP_RUN : OP_STEP, 0);
    end

    // Responder goes silent after five bytes.
    w = $urandom;
    exp_tx.push_back(8'hAA);
    exp_resp.push_back('{word: w, index: 7'd0});
    d0 = done_cnt;
    t0 = tx_dones;
    issue(OP_STEP, 1);
    wait_for(0, t0 + 1, 50, "to_cmd_tx_done");
    tick(2);
    for (int b = 3; b >= 0; b--) send_rx(w[8*b +: 8], $urandom_range(0, 3));
    send_rx(8'h5A, 0);
    n = 0;
    while (!o_error && n < 1100) begin
      @(negedge i_clock);
      n++;
    end
    check("timeout_window", (n >= 995 && n <= 1005), 1);
    check("timeout_error", o_error, 1);
    check("timeout_idle", o_busy, 0);
    check("timeout_no_done", done_cnt - d0, 0);
    check("timeout_queue_empty", exp_resp.size(), 0);

    // Reserved command is not accepted and leaves the sticky error alone.
    issue(OP_RSVD, 0);
    tick(2);
    check("rsvd_idle", o_busy, 0);
    check("rsvd_error_kept", o_error, 1);

    // Slow UART plus a command attempt while busy.
    tx_delay = 12800;
    for (int i = 0; i < NW; i++) dump_words[i] = $urandom;
    run_dump(OP_STEP, 1);
    tx_delay = 0;
    tick(5);
    check("no_queued_cmd", o_busy, 0);

    // Stray bytes while idle.
    r0 = resp_cnt;
    for (int i = 0; i < 4; i++) send_rx(8'($urandom), $urandom_range(0, 2));
    tick(5);
    check("stray_no_resp", resp_cnt - r0, 0);
    check("stray_no_error", o_error, 0);

    // Reset in the middle of a download.
    exp_tx.push_back(8'hFF);
    push_word_bytes(32'h12345678);
    t0 = tx_pulses;
    issue(OP_LOAD, 1);
    i_word = 32'h12345678;
    i_word_valid = 1'b1;
    wait_for(2, t0 + 3, 200, "midload_progress");
    i_reset = 1'b0;
    #1;
    check("midrst_busy", o_busy, 0);
    check("midrst_tx_signal", o_tx_signal, 0);
    check("midrst_tx_result", o_tx_result, 0);
    check("midrst_word_ready", o_word_ready, 0);
    check("midrst_resp_valid", o_resp_valid, 0);
    check("midrst_resp_word", o_resp_word, 0);
    check("midrst_resp_index", o_resp_index, 0);
    check("midrst_done", o_done, 0);
    check("midrst_error", o_error, 0);
    tick(3);
    i_word_valid = 1'b0;
    exp_tx.delete();
    @(negedge i_clock);
    i_reset = 1'b1;
    n = 0;
    while (tx_busy && n < 50) begin
      @(negedge i_clock);
      n++;
    end
    tick(3);
    check("midrst_release_idle", o_busy, 0);

    random_prog();
    run_load();

    finish_run();
  end

endmodule
